fpmul_seq_ctrl: RTL

Sequencer between the two hex keypad decoders and the mixed-precision FP multiplier core. It collects operand digits and qualifies them against the selected format (FP16: 4 digits, FP32: 8 digits). It then launches the multiplier with a start pulse, waits for completion with a timeout, and drives the ready/error status seen at top level. Enter/ce buttons arrive already synchronized and debounced; this block does the edge detection.

---
 rtl/fpmul_seq_ctrl_pkg.sv | 27 ++
 rtl/fpmul_seq_ctrl_if.sv | 39 +++
 rtl/fpmul_seq_ctrl_hex_shift_reg.sv | 62 ++++++
 rtl/fpmul_seq_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fpmul_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpmul_pkg
// Purpose  : Shared constants for the FP multiplier sequencer: digit counts
//            per operand format, format encodings and FSM state codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fpmul_pkg;

    // Hex digits per operand in each format
    localparam int DIG16 = 4;
    localparam int DIG32 = 8;

    // Format encoding as seen on data_type / mul_fmt
    localparam logic FMT_FP16 = 1'b0;
    localparam logic FMT_FP32 = 1'b1;

    // Sequencer states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ENTRY  = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fpmul_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fpmul_seq_ctrl_if
// Purpose  : Bundles the keypad/button inputs, multiplier handshake and the
//            operand/status outputs of the sequencer.
// Ports    : master - environment side (drives keys, buttons, mul_done)
//            slave  - sequencer side (drives operands, mul_start, status)
// Revision : 1.0 - initial release
// ============================================================================
interface fpmul_seq_ctrl_if;
    logic        data_type;
    logic        enter;
    logic        ce;
    logic        key1_vld;
    logic [3:0]  key1_code;
    logic        key2_vld;
    logic [3:0]  key2_code;
    logic        mul_done;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op_a_cnt;
    logic [3:0]  op_b_cnt;
    logic        mul_fmt;
    logic        mul_start;
    logic        busy;
    logic        ready;
    logic        error;

    modport master (
        output data_type, enter, ce, key1_vld, key1_code, key2_vld, key2_code, mul_done,
        input  op_a, op_b, op_a_cnt, op_b_cnt, mul_fmt, mul_start, busy, ready, error
    );

    modport slave (
        input  data_type, enter, ce, key1_vld, key1_code, key2_vld, key2_code, mul_done,
        output op_a, op_b, op_a_cnt, op_b_cnt, mul_fmt, mul_start, busy, ready, error
    );
endinterface
`default_nettype wire

// File: rtl/fpmul_seq_ctrl_hex_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : hex_shift_reg
// Purpose  : Operand digit collector. Shifts a hex digit in from the right
//            with a saturating digit count; full flags that the next digit
//            must be dropped.
// Ports    : clk, rst_n      - clock, async active-low reset
//            clr             - clear value and count (wins over shift_en)
//            shift_en        - digit strobe
//            code            - incoming hex digit
//            need            - digits required by the current format
//            value/count     - collected operand and digit count
//            full            - count has reached need
// Revision : 1.0 - initial release
// ============================================================================
module hex_shift_reg
    import fpmul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [3:0]  code,
    input  logic [3:0]  need,
    output logic [31:0] value,
    output logic [3:0]  count,
    output logic        full
);

    logic [31:0] value_q, value_d;
    logic [3:0]  count_q, count_d;

    // >= rather than == so a count can never run past need
    assign full = (count_q >= need);

    always_comb begin
        value_d = value_q;
        count_d = count_q;
        if (clr) begin
            value_d = '0;
            count_d = '0;
        end else if (shift_en && !full) begin
            value_d = {value_q[27:0], code};
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            count_q <= '0;
        end else begin
            value_q <= value_d;
            count_q <= count_d;
        end
    end

    assign value = value_q;
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/fpmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fpmul_seq_ctrl
// Purpose  : Sequencer between the hex keypads and the FP multiplier core.
//            Collects and qualifies operand digits, launches the multiplier,
//            waits for completion with a timeout and reports ready/error.
// Ports    : clk    - system clock (rising edge)
//            rst_n  - asynchronous active-low reset
//            bus    - fpmul_seq_ctrl_if.slave: keys, buttons, mul_done in;
//                     op_a/op_b, counts, mul_fmt, mul_start, busy, ready,
//                     error out
// Revision : 1.0 - initial release
// ============================================================================
module fpmul_seq_ctrl
    import fpmul_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int DIG16   = fpmul_pkg::DIG16,
    parameter int DIG32   = fpmul_pkg::DIG32
) (
    input  logic             clk,
    input  logic             rst_n,
    fpmul_seq_ctrl_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          error_q, error_d;
    logic          mul_fmt_q, mul_fmt_d;
    logic          mul_start_q, mul_start_d;
    logic          enter_q, ce_q, dt_q;

    logic          enter_rise, ce_rise, dt_toggle;
    logic [3:0]    need;
    logic          clr_ops, a_en, b_en;
    logic [31:0]   a_value, b_value;
    logic [3:0]    a_count, b_count;
    logic          a_full, b_full;

    // Buttons arrive synchronized; only the rising edge is a command
    assign enter_rise = bus.enter & ~enter_q;
    assign ce_rise    = bus.ce & ~ce_q;
    assign dt_toggle  = bus.data_type ^ dt_q;
    assign need       = (bus.data_type == FMT_FP32) ? 4'(DIG32) : 4'(DIG16);

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        error_d   = error_q;
        mul_fmt_d = mul_fmt_q;
        clr_ops   = 1'b0;
        a_en      = 1'b0;
        b_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enter_rise) begin
                    state_d = S_ENTRY;
                    clr_ops = 1'b1;
                end
            end
            S_ENTRY: begin
                if (ce_rise) begin
                    clr_ops = 1'b1;
                    error_d = 1'b0;
                end else if (enter_rise) begin
                    if (a_full && b_full && a_count == need && b_count == need)
                        state_d = S_LAUNCH;
                    else
                        error_d = 1'b1;
                end else if (dt_toggle) begin
                    clr_ops = 1'b1;
                end else begin
                    a_en = bus.key1_vld;
                    b_en = bus.key2_vld;
                    // An accepted digit clears error; a dropped one sets it,
                    // and a drop on either key wins in the same cycle.
                    if ((a_en && !a_full) || (b_en && !b_full))
                        error_d = 1'b0;
                    if ((a_en && a_full) || (b_en && b_full))
                        error_d = 1'b1;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ce_rise) begin
                    state_d = S_ENTRY;
                    clr_ops = 1'b1;
                    error_d = 1'b0;
                end else if (bus.mul_done) begin
                    state_d = S_DONE;
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    state_d = S_ENTRY;
                    error_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DONE: begin
                if (ce_rise) begin
                    state_d = S_ENTRY;
                    clr_ops = 1'b1;
                    error_d = 1'b0;
                end else if (enter_rise) begin
                    state_d = S_LAUNCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Format and timeout base are captured on every entry into LAUNCH
        if (state_d == S_LAUNCH) begin
            mul_fmt_d = bus.data_type;
            tmo_d     = '0;
        end
        mul_start_d = (state_d == S_LAUNCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            error_q     <= 1'b0;
            mul_fmt_q   <= 1'b0;
            mul_start_q <= 1'b0;
            enter_q     <= 1'b0;
            ce_q        <= 1'b0;
            dt_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            error_q     <= error_d;
            mul_fmt_q   <= mul_fmt_d;
            mul_start_q <= mul_start_d;
            enter_q     <= bus.enter;
            ce_q        <= bus.ce;
            dt_q        <= bus.data_type;
        end
    end

    hex_shift_reg u_op_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_ops),
        .shift_en (a_en),
        .code     (bus.key1_code),
        .need     (need),
        .value    (a_value),
        .count    (a_count),
        .full     (a_full)
    );

    hex_shift_reg u_op_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr_ops),
        .shift_en (b_en),
        .code     (bus.key2_code),
        .need     (need),
        .value    (b_value),
        .count    (b_count),
        .full     (b_full)
    );

    assign bus.op_a      = a_value;
    assign bus.op_b      = b_value;
    assign bus.op_a_cnt  = a_count;
    assign bus.op_b_cnt  = b_count;
    assign bus.mul_fmt   = mul_fmt_q;
    assign bus.mul_start = mul_start_q;
    assign bus.busy      = (state_q == S_LAUNCH) || (state_q == S_WAIT);
    assign bus.ready     = (state_q == S_DONE);
    assign bus.error     = error_q;

endmodule
`default_nettype wire
